mms_verify_initiator: RTL and testbench

- Clocked IEEE 802.3br Clause 99 MAC Merge verify state machine: the initiator side of the verify/respond handshake.
- Issues verify mPacket requests (send_v) to the MM transmit process and times the wait for a respond mPacket (rcv_r) from the link partner's respond machine.
- Retries up to a configurable limit, then declares preemption verified or failed.
- Sits in the MMS block next to the respond machine; drives the preemption-enable qualification seen by the express/preemptable TX arbiter.

---
 rtl/mms_verify_initiator_if.sv | 46 ++++
 rtl/mms_verify_initiator.sv | 124 ++++++++++++
 tb/tb_mms_verify_initiator.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mms_verify_initiator_if.sv
// ==========================================================================
// mms_verify_initiator_if : verify/respond handshake and status bundle
// Optional MMS_VERIFY_EVENT_EN adds event_clr/verify_event.  Rev 1.0
// ==========================================================================
`default_nettype none

interface mms_verify_initiator_if #(
  parameter int TIMER_W = 16,
  parameter int CNT_W   = 3
);
  logic               p_enable;
  logic               disable_verify;
  logic               link_fail;
  logic [TIMER_W-1:0] verify_time;
  logic               rcv_r;
  logic               send_v_ack;
  logic               send_v;
  logic               verified;
  logic               verify_fail;
  logic [CNT_W-1:0]   verify_cnt;
  logic [2:0]         verify_state;
`ifdef MMS_VERIFY_EVENT_EN
  logic               event_clr;
  logic               verify_event;

  modport master (
    input  p_enable, disable_verify, link_fail, verify_time, rcv_r, send_v_ack, event_clr,
    output send_v, verified, verify_fail, verify_cnt, verify_state, verify_event
  );
  modport slave (
    output p_enable, disable_verify, link_fail, verify_time, rcv_r, send_v_ack, event_clr,
    input  send_v, verified, verify_fail, verify_cnt, verify_state, verify_event
  );
`else
  modport master (
    input  p_enable, disable_verify, link_fail, verify_time, rcv_r, send_v_ack,
    output send_v, verified, verify_fail, verify_cnt, verify_state
  );
  modport slave (
    output p_enable, disable_verify, link_fail, verify_time, rcv_r, send_v_ack,
    input  send_v, verified, verify_fail, verify_cnt, verify_state
  );
`endif
endinterface

`default_nettype wire

// File: rtl/mms_verify_initiator.sv
// ==========================================================================
// mms_verify_initiator : 802.3br MAC Merge verify initiator state machine
// Optional MMS_VERIFY_EVENT_EN adds a sticky completion event.  Rev 1.0
// ==========================================================================
`default_nettype none

module mms_verify_initiator #(
  parameter int TIMER_W      = 16,
  parameter int CNT_W        = 3,
  parameter int VERIFY_LIMIT = 3
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  mms_verify_initiator_if.master bus
);

  typedef enum logic [2:0] {
    INIT_VERIFICATION = 3'd0,
    VERIFICATION_IDLE = 3'd1,
    SEND_VERIFY       = 3'd2,
    WAIT_FOR_RESPONSE = 3'd3,
    VERIFIED          = 3'd4,
    VERIFY_FAIL       = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(VERIFY_LIMIT);

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] load_val;
  logic               override;
  logic               timer_done;

  assign override   = bus.link_fail | bus.disable_verify | ~bus.p_enable;
  assign timer_done = (timer == '0);
  // A zero period would make the wait degenerate; treat it as one cycle.
  assign load_val   = (bus.verify_time == '0) ? TIMER_W'(1) : bus.verify_time;

  assign bus.verify_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= INIT_VERIFICATION;
      timer           <= '0;
      bus.send_v      <= 1'b0;
      bus.verified    <= 1'b0;
      bus.verify_fail <= 1'b0;
      bus.verify_cnt  <= '0;
    end else if (override) begin
      state           <= INIT_VERIFICATION;
      timer           <= '0;
      bus.send_v      <= 1'b0;
      bus.verified    <= 1'b0;
      bus.verify_fail <= 1'b0;
      bus.verify_cnt  <= '0;
    end else begin
      case (state)
        INIT_VERIFICATION: begin
          state <= VERIFICATION_IDLE;
        end
        VERIFICATION_IDLE: begin
          state          <= SEND_VERIFY;
          bus.send_v     <= 1'b1;
          bus.verify_cnt <= bus.verify_cnt + CNT_W'(1);
          timer          <= load_val;
        end
        SEND_VERIFY: begin
          state <= WAIT_FOR_RESPONSE;
          if (bus.send_v_ack && bus.send_v) bus.send_v <= 1'b0;
        end
        WAIT_FOR_RESPONSE: begin
          if (bus.rcv_r) begin
            state        <= VERIFIED;
            bus.verified <= 1'b1;
            bus.send_v   <= 1'b0;
          end else if (timer_done && (bus.verify_cnt < LIMIT)) begin
            // Re-entry keeps an unacknowledged request asserted rather than queueing another.
            state          <= SEND_VERIFY;
            bus.send_v     <= 1'b1;
            bus.verify_cnt <= bus.verify_cnt + CNT_W'(1);
            timer          <= load_val;
          end else if (timer_done) begin
            state           <= VERIFY_FAIL;
            bus.verify_fail <= 1'b1;
            bus.send_v      <= 1'b0;
          end else begin
            timer <= timer - TIMER_W'(1);
            if (bus.send_v_ack && bus.send_v) bus.send_v <= 1'b0;
          end
        end
        VERIFIED: begin
          bus.send_v <= 1'b0;
        end
        VERIFY_FAIL: begin
          bus.send_v <= 1'b0;
        end
        default: begin
          state <= INIT_VERIFICATION;
        end
      endcase
    end
  end

`ifdef MMS_VERIFY_EVENT_EN
  logic final_entry;

  assign final_entry = ~override && (state == WAIT_FOR_RESPONSE) &&
                       (bus.rcv_r || (timer_done && (bus.verify_cnt >= LIMIT)));

  // Sticky across the override so software can still observe the outcome.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.verify_event <= 1'b0;
    end else if (final_entry) begin
      bus.verify_event <= 1'b1;
    end else if (bus.event_clr) begin
      bus.verify_event <= 1'b0;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mms_verify_initiator.sv
// ==========================================================================
// tb_mms_verify_initiator : directed + randomized bench for the verify FSM
// Expectations come from attempt-window arithmetic.  Rev 1.0
// ==========================================================================
`default_nettype none

module tb_mms_verify_initiator;

  localparam int TIMER_W = 16;
  localparam int CNT_W   = 3;
  localparam int LIMIT   = 3;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  mms_verify_initiator_if #(.TIMER_W(TIMER_W), .CNT_W(CNT_W)) bus_if ();

  mms_verify_initiator #(
    .TIMER_W      (TIMER_W),
    .CNT_W        (CNT_W),
    .VERIFY_LIMIT (LIMIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic go_init(input string name);
    bus_if.disable_verify = 1'b1;
    bus_if.rcv_r          = 1'b0;
    bus_if.send_v_ack     = 1'b0;
    @(negedge clk);
    check({name, ".init_state"}, 32'(bus_if.verify_state), 0);
    check({name, ".init_send_v"}, 32'(bus_if.send_v), 0);
  endtask

  // Attempt a sends at cycle 2+(a-1)*(Teff+2) after the override clears; it
  // listens for rcv_r during the Teff+1 following cycles.
  task automatic run_scn(input int t, input int ratt, input int roff, input int ackd,
                         input bit stray, input bit clr_entry, input string name);
    int   teff, per, jr, fj, att, rises, first_f, cd;
    bit   pend, prev_sv, ack_prev;
    int   est;
    teff = (t == 0) ? 1 : t;
    per  = teff + 2;
    if (ratt >= 1 && ratt <= LIMIT) begin
      att = ratt;
      jr  = 2 + (ratt - 1) * per + roff;
      fj  = jr + 1;
      est = 4;
    end else begin
      att = LIMIT;
      jr  = -1;
      fj  = 2 + (LIMIT - 1) * per + teff + 2;
      est = 5;
    end
    bus_if.verify_time    = TIMER_W'(t);
    bus_if.p_enable       = 1'b1;
    bus_if.disable_verify = 1'b0;
    bus_if.link_fail      = 1'b0;
    bus_if.rcv_r          = 1'b0;
    bus_if.send_v_ack     = 1'b0;
`ifdef MMS_VERIFY_EVENT_EN
    bus_if.event_clr      = 1'b1;
`endif
    rises = 0; first_f = -1; pend = 0; prev_sv = 0; ack_prev = 0; cd = 0;
    for (int j = 1; j <= fj + 8; j++) begin
      @(negedge clk);
      if (ack_prev) check({name, ".ack_clears"}, 32'(bus_if.send_v), 0);
      if (bus_if.send_v && !prev_sv) begin
        rises++;
        if (rises <= att) begin
          check($sformatf("%s.rise%0d_cycle", name, rises), j, 2 + (rises - 1) * per);
          check($sformatf("%s.rise%0d_cnt", name, rises), 32'(bus_if.verify_cnt), rises);
        end
        pend = 1;
        cd   = ackd;
      end
      prev_sv = bus_if.send_v;
      if (first_f < 0 && (bus_if.verify_state == 3'd4 || bus_if.verify_state == 3'd5))
        first_f = j;
      bus_if.send_v_ack = 1'b0;
      if (pend) begin
        if (cd == 0) begin
          bus_if.send_v_ack = 1'b1;
          pend = 0;
        end else begin
          cd--;
        end
      end
      ack_prev     = bus_if.send_v_ack;
      bus_if.rcv_r = (j == jr) || (stray && (j == 1 || j == 2));
`ifdef MMS_VERIFY_EVENT_EN
      bus_if.event_clr = clr_entry && (j == jr);
`endif
    end
    bus_if.rcv_r      = 1'b0;
    bus_if.send_v_ack = 1'b0;
    check({name, ".requests"}, rises, att);
    check({name, ".final_cycle"}, first_f, fj);
    check({name, ".state"}, 32'(bus_if.verify_state), est);
    check({name, ".verified"}, 32'(bus_if.verified), (est == 4) ? 1 : 0);
    check({name, ".verify_fail"}, 32'(bus_if.verify_fail), (est == 5) ? 1 : 0);
    check({name, ".cnt"}, 32'(bus_if.verify_cnt), att);
    check({name, ".send_v_low"}, 32'(bus_if.send_v), 0);
`ifdef MMS_VERIFY_EVENT_EN
    check({name, ".event"}, 32'(bus_if.verify_event), 1);
`endif
  endtask

  initial begin
    int t, ra, ro, ad;
    bit st;
    tests = 0;
    fails = 0;
    rst_n                 = 1'b0;
    bus_if.p_enable       = 1'b1;
    bus_if.disable_verify = 1'b1;
    bus_if.link_fail      = 1'b0;
    bus_if.verify_time    = TIMER_W'(10);
    bus_if.rcv_r          = 1'b0;
    bus_if.send_v_ack     = 1'b0;
`ifdef MMS_VERIFY_EVENT_EN
    bus_if.event_clr      = 1'b0;
`endif

    // Reset values
    repeat (2) @(negedge clk);
    check("rst.state", 32'(bus_if.verify_state), 0);
    check("rst.send_v", 32'(bus_if.send_v), 0);
    check("rst.verified", 32'(bus_if.verified), 0);
    check("rst.verify_fail", 32'(bus_if.verify_fail), 0);
    check("rst.cnt", 32'(bus_if.verify_cnt), 0);
`ifdef MMS_VERIFY_EVENT_EN
    check("rst.event", 32'(bus_if.verify_event), 0);
`endif

    // disable_verify held from reset: machine parks in INIT
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("dis.state%0d", i), 32'(bus_if.verify_state), 0);
      check($sformatf("dis.send_v%0d", i), 32'(bus_if.send_v), 0);
    end

    // Ack two cycles after request, response five cycles after ack
    run_scn(10, 1, 7, 2, 1'b0, 1'b0, "basic");

    // One-cycle link_fail from VERIFIED, then a full failing sequence
    bus_if.link_fail = 1'b1;
    @(negedge clk);
    check("lfail.state", 32'(bus_if.verify_state), 0);
    check("lfail.verified", 32'(bus_if.verified), 0);
    check("lfail.cnt", 32'(bus_if.verify_cnt), 0);
    run_scn(10, LIMIT + 1, 1, 3, 1'b0, 1'b0, "fail3");

`ifdef MMS_VERIFY_EVENT_EN
    bus_if.event_clr = 1'b1;
    @(negedge clk);
    bus_if.event_clr = 1'b0;
    check("evclr.event", 32'(bus_if.verify_event), 0);
`endif

    // Response coincident with last-attempt expiry; clear coincident with entry
    go_init("coinc");
    run_scn(5, LIMIT, 6, 1, 1'b0, 1'b1, "coinc");

    // verify_time of zero behaves as one
    go_init("t0f");
    run_scn(0, LIMIT + 1, 1, 0, 1'b1, 1'b0, "t0fail");
    go_init("t0r");
    run_scn(0, 2, 2, 1, 1'b0, 1'b0, "t0resp");

    // Randomized scenarios
    for (int k = 0; k < 8; k++) begin
      t  = $urandom_range(0, 6);
      ra = $urandom_range(1, LIMIT + 1);
      ro = $urandom_range(1, ((t == 0) ? 1 : t) + 1);
      ad = $urandom_range(0, (t == 0) ? 1 : t);
      st = 1'($urandom_range(0, 1));
      go_init($sformatf("rnd%0d", k));
      run_scn(t, ra, ro, ad, st, 1'b0, $sformatf("rnd%0d", k));
    end

    // Asynchronous reset in the middle of a wait
    go_init("arst");
    bus_if.verify_time    = TIMER_W'(20);
    bus_if.disable_verify = 1'b0;
    repeat (6) @(negedge clk);
    check("arst.pre_state", 32'(bus_if.verify_state), 3);
    check("arst.pre_cnt", 32'(bus_if.verify_cnt), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst.state", 32'(bus_if.verify_state), 0);
    check("arst.send_v", 32'(bus_if.send_v), 0);
    check("arst.cnt", 32'(bus_if.verify_cnt), 0);
    check("arst.verified", 32'(bus_if.verified), 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
